// File: rtl/uartms_pkg.sv
// Shared UART types and constants for the Tx engine and the baud generator.
package uartms_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 12;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned IDX_W  = 3;

  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_EVEN = 2'd1;
  localparam logic [1:0] PRI_ODD  = 2'd2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} tx_state_t;

  // Frame settings captured at launch and held for the whole frame
  typedef struct packed {
    logic [1:0]        pri_mod;
    logic              stop_bit;
    logic [BAUD_W-1:0] baud_16x;
  } tx_cfg_t;

  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PRI_EVEN) || (mode == PRI_ODD);
  endfunction

endpackage

// File: rtl/uartms_tx_core_if.sv
// Tx FIFO read port: show-ahead head, empty flag and pop strobe.
interface uartms_tx_core_if;

  logic                            tx_fifo_empty;
  logic [uartms_pkg::DATA_W-1:0]   tx_fifo_rd_data;
  logic                            tx_fifo_rd_en;

  modport master (input tx_fifo_empty, input tx_fifo_rd_data, output tx_fifo_rd_en);
  modport slave  (output tx_fifo_empty, output tx_fifo_rd_data, input tx_fifo_rd_en);

endinterface

// File: rtl/uartms_baud_gen.sv
// 16x baud divider: counts 0..div and flags the wrap cycle; sync clear restarts the period.
module uartms_baud_gen
  import uartms_pkg::*;
(
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic [BAUD_W-1:0] div,
  output logic              tick_c
);

  logic [BAUD_W-1:0] cnt;

  assign tick_c = (cnt == div);

  // cnt never passes div, so 12'hFFF wraps cleanly without overflow
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uartms_tx_core.sv
// UART transmit engine: pops bytes from the Tx FIFO and serialises them on txd.
module uartms_tx_core
  import uartms_pkg::*;
#(
  parameter int unsigned DW = DATA_W
)(
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic                   cfg_tx_enable,
  input  logic                   cfg_tx_stop_bit,
  input  logic [1:0]             cfg_pri_mod,
  input  logic [BAUD_W-1:0]      cfg_baud_16x,
  uartms_tx_core_if.master       tx_fifo,
  output logic                   txd,
  output logic                   tx_busy
);

  tx_state_t         state;
  tx_cfg_t           cfg_lat;
  logic [DW-1:0]     shift_reg;
  logic [TICK_W-1:0] bit_cnt;
  logic [IDX_W-1:0]  data_idx;
  logic              par_bit;

  logic tick_c;
  logic bit_end_c;
  logic last_stop_c;
  logic launch_c;
  logic baud_clr_c;

  assign bit_end_c   = tick_c && (bit_cnt == {TICK_W{1'b1}});
  assign last_stop_c = bit_end_c &&
                       ((state == STOP2) || ((state == STOP1) && !cfg_lat.stop_bit));
  // Pop strobe is the launch decision itself, so the head byte is taken in the same cycle
  assign launch_c    = reset_n && cfg_tx_enable && !tx_fifo.tx_fifo_empty &&
                       ((state == IDLE) || last_stop_c);
  assign baud_clr_c  = launch_c || (state == IDLE);

  assign tx_fifo.tx_fifo_rd_en = launch_c;

  uartms_baud_gen u_baud_gen (
    .mclk    (mclk),
    .reset_n (reset_n),
    .clr     (baud_clr_c),
    .div     (cfg_lat.baud_16x),
    .tick_c  (tick_c)
  );

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      txd       <= 1'b1;
      tx_busy   <= 1'b0;
      cfg_lat   <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      data_idx  <= '0;
      par_bit   <= 1'b0;
    end else if (launch_c) begin
      state     <= START;
      txd       <= 1'b0;
      tx_busy   <= 1'b1;
      cfg_lat   <= '{pri_mod: cfg_pri_mod, stop_bit: cfg_tx_stop_bit, baud_16x: cfg_baud_16x};
      shift_reg <= tx_fifo.tx_fifo_rd_data;
      bit_cnt   <= '0;
      data_idx  <= '0;
      par_bit   <= (cfg_pri_mod == PRI_ODD) ? ~^tx_fifo.tx_fifo_rd_data
                                            :  ^tx_fifo.tx_fifo_rd_data;
    end else if ((state != IDLE) && tick_c) begin
      bit_cnt <= bit_cnt + TICK_W'(1);
      if (bit_end_c) begin
        case (state)
          START: begin
            state <= DATA;
            txd   <= shift_reg[0];
          end
          DATA: begin
            if (data_idx == IDX_W'(DW - 1)) begin
              if (has_parity(cfg_lat.pri_mod)) begin
                state <= PARITY;
                txd   <= par_bit;
              end else begin
                state <= STOP1;
                txd   <= 1'b1;
              end
            end else begin
              data_idx  <= data_idx + IDX_W'(1);
              shift_reg <= shift_reg >> 1;
              txd       <= shift_reg[1];
            end
          end
          PARITY: begin
            state <= STOP1;
            txd   <= 1'b1;
          end
          STOP1: begin
            txd <= 1'b1;
            if (cfg_lat.stop_bit) begin
              state <= STOP2;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uartms_tx_core.sv
// Scoreboard bench for uartms_tx_core: FIFO model feeds bytes, monitor decodes txd per cycle.
module tb_uartms_tx_core;
  import uartms_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pri;
    logic       stop;
    int         bt;
  } exp_t;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_tx_enable = 1'b1;
  logic        cfg_tx_stop_bit = 1'b0;
  logic [1:0]  cfg_pri_mod = 2'd0;
  logic [11:0] cfg_baud_16x = 12'd0;
  logic        txd;
  logic        tx_busy;

  uartms_tx_core_if bus();

  logic [7:0]  fifo_mem [64];
  logic [31:0] wr_ptr = 0;
  logic [31:0] rd_ptr = 0;

  assign bus.tx_fifo_empty   = (wr_ptr == rd_ptr);
  assign bus.tx_fifo_rd_data = fifo_mem[rd_ptr[5:0]];

  uartms_tx_core #(.DW(8)) dut (
    .mclk            (mclk),
    .reset_n         (reset_n),
    .cfg_tx_enable   (cfg_tx_enable),
    .cfg_tx_stop_bit (cfg_tx_stop_bit),
    .cfg_pri_mod     (cfg_pri_mod),
    .cfg_baud_16x    (cfg_baud_16x),
    .tx_fifo         (bus.master),
    .txd             (txd),
    .tx_busy         (tx_busy)
  );

  always #5 mclk = ~mclk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rd_cnt  = 0;
  int   last_fall = 0;
  logic busy_prev = 1'b0;
  logic mon_kill  = 1'b0;
  int   start_q [$];
  int   rd_q [$];
  exp_t exp_q [$];

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic sync();
    @(posedge mclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    exp_t e;
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
    e.data = b;
    e.pri  = cfg_pri_mod;
    e.stop = cfg_tx_stop_bit;
    e.bt   = 16 * (int'(cfg_baud_16x) + 1);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0 || bus.tx_fifo_empty !== 1'b1) && n < 20000) begin
      @(negedge mclk);
      n++;
    end
    chk({tag, "_idle_timeout"}, int'(n >= 20000), 0);
    @(negedge mclk);
  endtask

  task automatic wait_start(input int cnt);
    int n = 0;
    while (start_q.size() < cnt && n < 5000) begin
      @(negedge mclk);
      n++;
    end
    chk("start_timeout", int'(n >= 5000), 0);
  endtask

  // FIFO model pops on the strobe; cycle counter for timing checks
  always @(posedge mclk) begin
    cyc <= cyc + 1;
    if (bus.tx_fifo_rd_en === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge mclk) begin
    if (bus.tx_fifo_rd_en === 1'b1) begin
      rd_q.push_back(cyc);
      rd_cnt++;
      chk("rd_en_while_empty", int'(bus.tx_fifo_empty), 0);
    end
    if (busy_prev && !tx_busy) last_fall = cyc;
    busy_prev = tx_busy;
  end

  // Frame monitor: builds the expected bit sequence and checks txd/tx_busy every cycle
  initial begin
    exp_t e;
    logic bits [12];
    int   nb;
    int   mism;
    forever begin
      @(negedge mclk);
      if (reset_n && !mon_kill && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          start_q.push_back(cyc);
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1 + i] = e.data[i];
          nb = 9;
          if (e.pri == 2'd1) begin
            bits[nb] = ^e.data;
            nb++;
          end else if (e.pri == 2'd2) begin
            bits[nb] = ~^e.data;
            nb++;
          end
          bits[nb] = 1'b1;
          nb++;
          if (e.stop) begin
            bits[nb] = 1'b1;
            nb++;
          end
          mism = 0;
          for (int c = 0; c < nb * e.bt; c++) begin
            if (c != 0) @(negedge mclk);
            if (mon_kill || !reset_n) break;
            if (txd !== bits[c / e.bt] || tx_busy !== 1'b1) mism++;
            if (c % e.bt == e.bt - 1) begin
              chk($sformatf("frame_%02h_bit%0d", e.data, c / e.bt), mism, 0);
              mism = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int r0;
    int n0;
    int k;

    repeat (3) @(negedge mclk);
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_rd_en", int'(bus.tx_fifo_rd_en), 0);
    reset_n = 1'b1;
    sync();

    // 8N1 at minimum bit time
    r0 = rd_cnt;
    start_q.delete();
    push(8'h55);
    wait_idle("t1");
    chk("t1_rd_pulses", rd_cnt - r0, 1);
    if (start_q.size() == 1) chk("t1_len", last_fall - start_q[0], 160);
    else chk("t1_frames", start_q.size(), 1);

    // Even parity, two stop bits, 64-cycle bit time
    sync();
    cfg_baud_16x = 12'd3; cfg_pri_mod = 2'd1; cfg_tx_stop_bit = 1'b1;
    start_q.delete();
    push(8'h07);
    wait_idle("t2");
    if (start_q.size() == 1) chk("t2_len", last_fall - start_q[0], 768);
    else chk("t2_frames", start_q.size(), 1);

    // Odd parity, then mode 3 behaves as no parity
    sync();
    cfg_baud_16x = 12'd0; cfg_pri_mod = 2'd2; cfg_tx_stop_bit = 1'b0;
    start_q.delete();
    push(8'h00);
    wait_idle("t3a");
    if (start_q.size() == 1) chk("t3_odd_len", last_fall - start_q[0], 176);
    else chk("t3a_frames", start_q.size(), 1);
    sync();
    cfg_pri_mod = 2'd3;
    start_q.delete();
    push(8'h00);
    wait_idle("t3b");
    if (start_q.size() == 1) chk("t3_pri3_len", last_fall - start_q[0], 160);
    else chk("t3b_frames", start_q.size(), 1);

    // Back-to-back frames with zero gap
    sync();
    cfg_pri_mod = 2'd0;
    start_q.delete();
    rd_q.delete();
    push(8'h12); push(8'hA7); push(8'hFF);
    wait_idle("t4");
    chk("t4_rd_count", rd_q.size(), 3);
    chk("t4_frame_count", start_q.size(), 3);
    if (rd_q.size() == 3 && start_q.size() == 3) begin
      chk("t4_rd_gap1", rd_q[1] - rd_q[0], 160);
      chk("t4_rd_gap2", rd_q[2] - rd_q[1], 160);
      chk("t4_start_gap1", start_q[1] - start_q[0], 160);
      chk("t4_start_gap2", start_q[2] - start_q[1], 160);
      chk("t4_txd_fall_after_rd", start_q[0] - rd_q[0], 1);
      chk("t4_total_len", last_fall - start_q[0], 480);
    end

    // Enable dropped mid-frame: current frame finishes, next waits
    sync();
    start_q.delete();
    push(8'h3C); push(8'hC3);
    wait_start(1);
    repeat (50) @(negedge mclk);
    sync();
    cfg_tx_enable = 1'b0;
    k = 0;
    while (tx_busy !== 1'b0 && k < 5000) begin
      @(negedge mclk);
      k++;
    end
    chk("t5_busy_timeout", int'(k >= 5000), 0);
    repeat (100) @(negedge mclk);
    chk("t5_txd_idle", int'(txd), 1);
    chk("t5_busy_idle", int'(tx_busy), 0);
    chk("t5_fifo_level", int'(wr_ptr - rd_ptr), 1);
    chk("t5_frames", start_q.size(), 1);
    if (start_q.size() == 1) chk("t5_len", last_fall - start_q[0], 160);
    sync();
    n0 = cyc;
    cfg_tx_enable = 1'b1;
    wait_start(2);
    if (start_q.size() == 2) chk("t5_restart_delay", start_q[1] - n0, 1);
    wait_idle("t5");

    // Baud change mid-frame must not disturb the frame in flight
    sync();
    start_q.delete();
    push(8'h9E);
    wait_start(1);
    repeat (20) @(negedge mclk);
    sync();
    cfg_baud_16x = 12'd9;
    wait_idle("t6a");
    if (start_q.size() == 1) chk("t6_len_baud_change", last_fall - start_q[0], 160);
    sync();
    cfg_baud_16x = 12'd0;

    // Async reset in the data phase
    start_q.delete();
    push(8'hA5);
    wait_start(1);
    repeat (40) @(negedge mclk);
    sync();
    mon_kill = 1'b1;
    @(posedge mclk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_txd", int'(txd), 1);
    chk("t6_rst_busy", int'(tx_busy), 0);
    chk("t6_rst_rd_en", int'(bus.tx_fifo_rd_en), 0);
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
    mon_kill = 1'b0;
    repeat (5) @(negedge mclk);
    chk("t6_post_rst_txd", int'(txd), 1);
    chk("t6_post_rst_busy", int'(tx_busy), 0);

    // Normal traffic after reset
    sync();
    start_q.delete();
    push(8'h81);
    wait_idle("t7");
    if (start_q.size() == 1) chk("t7_len", last_fall - start_q[0], 160);
    else chk("t7_frames", start_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
